// File: rtl/char_ram_pkg.sv
// Shared types and widths for the character RAM port-A arbiter.
package char_ram_pkg;

   localparam int ADR_W = 16;
   localparam int DAT_W = 8;

   // Sequencer states: arbitrate, run the RAM access, then acknowledge.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK    = 2'd2
   } state_t;

   // Which requester currently owns (or last owned) the RAM port.
   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_t;

endpackage

// File: rtl/char_ram_rr_pick.sv
// Two-input requester picker for the character RAM arbiter.
// Combinational only; the last-grant pointer lives in the parent so the
// pointer only advances when a transaction actually completes.
//   pRoundRobin = 1 : on a tie, grant the requester that was not granted last
//   pRoundRobin = 0 : on a tie, the CPU always wins
module char_ram_rr_pick
   import char_ram_pkg::*;
#(
   parameter int pRoundRobin = 1
) (
   input  logic i_c_req,
   input  logic i_d_req,
   input  logic i_last,
   output logic o_valid,
   output logic o_owner
);

   // Pick an owner from the current request levels and the last-grant pointer.
   always_comb begin
      o_valid = i_c_req | i_d_req;
      o_owner = OWN_CPU;
      if (i_c_req && i_d_req) begin
         if ((pRoundRobin != 0) && (i_last == OWN_CPU)) begin
            o_owner = OWN_DMA;
         end
      end else if (i_d_req) begin
         o_owner = OWN_DMA;
      end
   end

endmodule

// File: rtl/char_ram_port_arb.sv
// Character/font RAM port-A arbiter and sequencer.
// Shares the host-side byte port of the char RAM between the CPU bus slave
// and the font-upload DMA. Each transaction is IDLE -> ACCESS -> ACK; the
// acknowledge pulse appears in the cycle after ACK, and IDLE refuses to grant
// while that pulse is visible so a requester has one edge to drop or renew
// its level request before it can be sampled again.
// Optional feature: define CHAR_RAM_ARB_WRPROT_EN to suppress CPU writes below
// pRomTop while wp_lock_i is high (the write is still acknowledged).
module char_ram_port_arb
   import char_ram_pkg::*;
#(
   parameter int               pReadLatency = 2,
   parameter int               pRoundRobin  = 1,
   parameter logic [ADR_W-1:0] pRomTop      = 16'h2000
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   // CPU requester
   input  logic             c_req_i,
   input  logic             c_we_i,
   input  logic [ADR_W-1:0] c_adr_i,
   input  logic [DAT_W-1:0] c_dat_i,
   output logic [DAT_W-1:0] c_dat_o,
   output logic             c_ack_o,
   // DMA requester
   input  logic             d_req_i,
   input  logic             d_we_i,
   input  logic [ADR_W-1:0] d_adr_i,
   input  logic [DAT_W-1:0] d_dat_i,
   output logic [DAT_W-1:0] d_dat_o,
   output logic             d_ack_o,
   // Write protect
   input  logic             wp_lock_i,
   // RAM port A
   output logic             ram_cs_o,
   output logic             ram_we_o,
   output logic [ADR_W-1:0] ram_adr_o,
   output logic [DAT_W-1:0] ram_dat_o,
   input  logic [DAT_W-1:0] ram_dat_i,
   // Status
   output logic             busy_o
);

   localparam int              CNT_W    = $clog2(pReadLatency + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(pReadLatency - 1);

   // Sequencer state and latched transaction
   state_t             r_state,   w_state_next;
   logic [CNT_W-1:0]   r_cnt,     w_cnt_next;
   owner_t             r_owner,   w_owner_next;
   owner_t             r_last,    w_last_next;
   logic               r_we,      w_we_next;
   logic [ADR_W-1:0]   r_adr,     w_adr_next;
   logic [DAT_W-1:0]   r_dat,     w_dat_next;

   // Registered outputs
   logic               r_ram_cs,  w_ram_cs_next;
   logic               r_ram_we,  w_ram_we_next;
   logic [DAT_W-1:0]   r_c_dat,   w_c_dat_next;
   logic [DAT_W-1:0]   r_d_dat,   w_d_dat_next;
   logic               r_c_ack,   w_c_ack_next;
   logic               r_d_ack,   w_d_ack_next;
   logic               r_busy,    w_busy_next;

   // Arbitration and selected-request fields
   logic               w_grant_valid;
   logic               w_grant_owner;
   logic               w_sel_we;
   logic [ADR_W-1:0]   w_sel_adr;
   logic [DAT_W-1:0]   w_sel_dat;
   logic               w_wp_block;

   char_ram_rr_pick #(
      .pRoundRobin (pRoundRobin)
   ) u_pick (
      .i_c_req (c_req_i),
      .i_d_req (d_req_i),
      .i_last  (r_last),
      .o_valid (w_grant_valid),
      .o_owner (w_grant_owner)
   );

   assign w_sel_we  = (w_grant_owner == OWN_DMA) ? d_we_i  : c_we_i;
   assign w_sel_adr = (w_grant_owner == OWN_DMA) ? d_adr_i : c_adr_i;
   assign w_sel_dat = (w_grant_owner == OWN_DMA) ? d_dat_i : c_dat_i;

`ifdef CHAR_RAM_ARB_WRPROT_EN
   // Only CPU writes into the locked low region are blocked; DMA uploads
   // must always be able to replace the font.
   assign w_wp_block = wp_lock_i && (w_grant_owner == OWN_CPU) && c_we_i
                       && (c_adr_i < pRomTop);
`else
   // Protection compiled out: every write reaches the RAM.
   assign w_wp_block = 1'b0;
   logic w_unused;
   assign w_unused = &{1'b0, wp_lock_i, pRomTop};
`endif

   // State and output registers; reset parks everything at zero with the
   // pointer on the DMA so the CPU wins the first tie.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_owner  <= OWN_CPU;
         r_last   <= OWN_DMA;
         r_we     <= 1'b0;
         r_adr    <= '0;
         r_dat    <= '0;
         r_ram_cs <= 1'b0;
         r_ram_we <= 1'b0;
         r_c_dat  <= '0;
         r_d_dat  <= '0;
         r_c_ack  <= 1'b0;
         r_d_ack  <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_cnt    <= w_cnt_next;
         r_owner  <= w_owner_next;
         r_last   <= w_last_next;
         r_we     <= w_we_next;
         r_adr    <= w_adr_next;
         r_dat    <= w_dat_next;
         r_ram_cs <= w_ram_cs_next;
         r_ram_we <= w_ram_we_next;
         r_c_dat  <= w_c_dat_next;
         r_d_dat  <= w_d_dat_next;
         r_c_ack  <= w_c_ack_next;
         r_d_ack  <= w_d_ack_next;
         r_busy   <= w_busy_next;
      end
   end

   // Next-state and next-output logic for the arbitration sequencer.
   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = r_cnt;
      w_owner_next  = r_owner;
      w_last_next   = r_last;
      w_we_next     = r_we;
      w_adr_next    = r_adr;
      w_dat_next    = r_dat;
      w_ram_cs_next = r_ram_cs;
      w_ram_we_next = r_ram_we;
      w_c_dat_next  = r_c_dat;
      w_d_dat_next  = r_d_dat;
      w_c_ack_next  = 1'b0;
      w_d_ack_next  = 1'b0;

      case (r_state)
         IDLE: begin
            w_ram_cs_next = 1'b0;
            w_ram_we_next = 1'b0;
            // While an ack is visible the requester has not yet reacted,
            // so sampling its request now could reissue the same access.
            if (w_grant_valid && !r_c_ack && !r_d_ack) begin
               w_owner_next  = owner_t'(w_grant_owner);
               w_we_next     = w_sel_we;
               w_adr_next    = w_sel_adr;
               w_dat_next    = w_sel_dat;
               w_ram_cs_next = !w_wp_block;
               w_ram_we_next = w_sel_we && !w_wp_block;
               w_cnt_next    = '0;
               w_state_next  = ACCESS;
            end
         end

         ACCESS: begin
            if (r_we) begin
               // Writes occupy the port for a single cycle.
               w_ram_cs_next = 1'b0;
               w_ram_we_next = 1'b0;
               w_state_next  = ACK;
            end else if (r_cnt == CNT_LAST) begin
               // Final select cycle: RAM output is valid now.
               w_ram_cs_next = 1'b0;
               if (r_owner == OWN_CPU) begin
                  w_c_dat_next = ram_dat_i;
               end else begin
                  w_d_dat_next = ram_dat_i;
               end
               w_state_next = ACK;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end

         ACK: begin
            w_ram_cs_next = 1'b0;
            w_ram_we_next = 1'b0;
            if (r_owner == OWN_CPU) begin
               w_c_ack_next = 1'b1;
            end else begin
               w_d_ack_next = 1'b1;
            end
            w_last_next  = r_owner;
            w_state_next = IDLE;
         end

         default: begin
            w_ram_cs_next = 1'b0;
            w_ram_we_next = 1'b0;
            w_state_next  = IDLE;
         end
      endcase

      w_busy_next = (w_state_next != IDLE);
   end

   assign c_dat_o   = r_c_dat;
   assign c_ack_o   = r_c_ack;
   assign d_dat_o   = r_d_dat;
   assign d_ack_o   = r_d_ack;
   assign ram_cs_o  = r_ram_cs;
   assign ram_we_o  = r_ram_we;
   assign ram_adr_o = r_adr;
   assign ram_dat_o = r_dat;
   assign busy_o    = r_busy;

endmodule

// File: tb/tb_char_ram_port_arb.sv
// Self-checking bench for char_ram_port_arb (round-robin instance with a RAM
// model, plus a fixed-priority instance for starvation behaviour).
module tb_char_ram_port_arb;

   localparam int L = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // Round-robin DUT signals
   logic        c_req, c_we, d_req, d_we, wp_lock;
   logic [15:0] c_adr, d_adr;
   logic [7:0]  c_dat, d_dat;
   logic [7:0]  c_dat_o, d_dat_o, ram_dat_o, ram_dat_i;
   logic        c_ack_o, d_ack_o, ram_cs_o, ram_we_o, busy_o;
   logic [15:0] ram_adr_o;

   // Fixed-priority DUT signals
   logic        fc_req, fd_req;
   logic [7:0]  fc_dat_o, fd_dat_o, f_ram_dat_o;
   logic        fc_ack_o, fd_ack_o, f_ram_cs, f_ram_we, f_busy;
   logic [15:0] f_ram_adr;
   logic [7:0]  f_ram_rd = 8'h5A;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   char_ram_port_arb #(.pReadLatency(L), .pRoundRobin(1), .pRomTop(16'h2000)) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .c_req_i(c_req), .c_we_i(c_we), .c_adr_i(c_adr), .c_dat_i(c_dat),
      .c_dat_o(c_dat_o), .c_ack_o(c_ack_o),
      .d_req_i(d_req), .d_we_i(d_we), .d_adr_i(d_adr), .d_dat_i(d_dat),
      .d_dat_o(d_dat_o), .d_ack_o(d_ack_o),
      .wp_lock_i(wp_lock),
      .ram_cs_o(ram_cs_o), .ram_we_o(ram_we_o), .ram_adr_o(ram_adr_o),
      .ram_dat_o(ram_dat_o), .ram_dat_i(ram_dat_i), .busy_o(busy_o));

   char_ram_port_arb #(.pReadLatency(L), .pRoundRobin(0), .pRomTop(16'h2000)) u_fp (
      .clk_i(clk), .rst_ni(rst_n),
      .c_req_i(fc_req), .c_we_i(1'b0), .c_adr_i(16'h0010), .c_dat_i(8'h00),
      .c_dat_o(fc_dat_o), .c_ack_o(fc_ack_o),
      .d_req_i(fd_req), .d_we_i(1'b0), .d_adr_i(16'h0020), .d_dat_i(8'h00),
      .d_dat_o(fd_dat_o), .d_ack_o(fd_ack_o),
      .wp_lock_i(1'b0),
      .ram_cs_o(f_ram_cs), .ram_we_o(f_ram_we), .ram_adr_o(f_ram_adr),
      .ram_dat_o(f_ram_dat_o), .ram_dat_i(f_ram_rd), .busy_o(f_busy));

   // ---------------- RAM model ----------------
   // Unwritten locations return a fixed pattern; read data is only valid in
   // the L-th consecutive select cycle, garbage otherwise.
   logic [7:0] wmem [0:65535];
   bit         wval [0:65535];
   int         cs_run = 0;

   function automatic logic [7:0] pat(input logic [15:0] a);
      if (a == 16'h0041) return 8'h3C;
      return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
   endfunction

   function automatic logic [7:0] rd_mem(input logic [15:0] a);
      return wval[a] ? wmem[a] : pat(a);
   endfunction

   always @(posedge clk) begin
      if (ram_cs_o && ram_we_o) begin
         wmem[ram_adr_o] <= ram_dat_o;
         wval[ram_adr_o] <= 1'b1;
      end
      cs_run <= (ram_cs_o && !ram_we_o) ? cs_run + 1 : 0;
   end

   assign ram_dat_i = (ram_cs_o && !ram_we_o && cs_run == L - 1) ? rd_mem(ram_adr_o) : 8'hEE;

   // ---------------- scoreboard ----------------
   typedef struct {
      logic        we;
      logic [15:0] adr;
      logic [7:0]  dat;
      int          issue;
      bit          chk_lat;
   } item_t;

   item_t cq[$];
   item_t dq[$];
   bit    ack_log[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    fc_acks  = 0;
   int    fd_acks  = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic sb_ack(input bit is_dma);
      item_t      it;
      logic [7:0] got;
      if (is_dma ? (dq.size() == 0) : (cq.size() == 0)) begin
         check_val("spurious_ack", {31'd0, is_dma}, 32'hFFFF_FFFF);
         return;
      end
      if (is_dma) it = dq.pop_front();
      else        it = cq.pop_front();
      got = is_dma ? d_dat_o : c_dat_o;
      ack_log.push_back(is_dma);
      if (it.chk_lat) check_val("ack_latency", cyc - it.issue, it.we ? 3 : 2 + L);
      if (!it.we) check_val("read_data", got, it.dat);
      $display("txn %s we=%0b adr=%h dat=%h lat=%0d", is_dma ? "DMA" : "CPU",
               it.we, it.adr, it.we ? it.dat : got, cyc - it.issue);
   endtask

   // Output monitor: acks against the scoreboard, RAM select shape.
   logic        prev_cs = 1'b0;
   int          run = 0;
   logic [15:0] run_adr;
   logic        run_we;
   initial begin
      forever begin
         @(negedge clk);
         if (fc_ack_o) fc_acks++;
         if (fd_ack_o) fd_acks++;
         if (!rst_n) begin
            prev_cs = 1'b0;
            run     = 0;
         end else begin
            if (c_ack_o) sb_ack(1'b0);
            if (d_ack_o) sb_ack(1'b1);
            if (ram_cs_o) begin
               if (!prev_cs) begin
                  run     = 1;
                  run_adr = ram_adr_o;
                  run_we  = ram_we_o;
               end else begin
                  run++;
                  check_val("ram_adr_stable", ram_adr_o, run_adr);
               end
               check_val("busy_during_cs", busy_o, 1);
            end else if (prev_cs) begin
               check_val("cs_width", run, run_we ? 1 : L);
            end
            prev_cs = ram_cs_o;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_ack(input bit is_dma, input string tag);
      int k;
      for (k = 0; k < 40; k++) begin
         @(negedge clk);
         if (is_dma ? d_ack_o : c_ack_o) break;
      end
      if (k == 40) check_val({tag, "_timeout"}, 0, 1);
   endtask

   // Issue one transaction and wait for its ack; keep=1 leaves req high so
   // the next call renews it without a gap.
   task automatic txn(input bit is_dma, input bit we, input logic [15:0] adr,
                      input logic [7:0] dat, input bit keep, input bit chk_lat);
      item_t it;
      it.we = we; it.adr = adr; it.dat = we ? dat : rd_mem(adr);
      it.issue = cyc; it.chk_lat = chk_lat;
      if (is_dma) begin
         d_we = we; d_adr = adr; d_dat = dat; d_req = 1'b1; dq.push_back(it);
      end else begin
         c_we = we; c_adr = adr; c_dat = dat; c_req = 1'b1; cq.push_back(it);
      end
      wait_ack(is_dma, "txn");
      @(posedge clk); #1;
      if (!keep) begin
         if (is_dma) d_req = 1'b0;
         else        c_req = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      item_t it;
      int    k;
      c_req = 0; c_we = 0; c_adr = 0; c_dat = 0;
      d_req = 0; d_we = 0; d_adr = 0; d_dat = 0;
      wp_lock = 0; fc_req = 0; fd_req = 0;
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_ctrl", {c_ack_o, d_ack_o, ram_cs_o, ram_we_o, busy_o}, 0);
      check_val("rst_ram_adr", ram_adr_o, 0);
      check_val("rst_dat", {c_dat_o, d_dat_o, ram_dat_o}, 0);
      rst_n = 1;
      @(posedge clk); #1;
      check_val("idle_busy", busy_o, 0);

      // Both requesters read back-to-back: grants must alternate from CPU.
      ack_log.delete();
      fork
         begin
            for (int i = 0; i < 4; i++) txn(1'b0, 1'b0, 16'(16'h0300 + i), 8'h00, i < 3, 1'b0);
         end
         begin
            for (int i = 0; i < 4; i++) txn(1'b1, 1'b0, 16'(16'h0400 + i), 8'h00, i < 3, 1'b0);
         end
      join
      check_val("rr_ack_count", ack_log.size(), 8);
      for (int i = 0; i < ack_log.size(); i++) check_val("rr_order", ack_log[i], i % 2);

      // CPU-only read of 0x0041.
      ack_log.delete();
      txn(1'b0, 1'b0, 16'h0041, 8'h00, 1'b0, 1'b1);
      check_val("c_dat_3c", c_dat_o, 8'h3C);
      repeat (3) @(posedge clk); #1;
      check_val("cpu_only_acks", ack_log.size(), 1);

      // DMA write, then CPU readback; DMA read data must not move.
      txn(1'b1, 1'b1, 16'h1234, 8'hA5, 1'b0, 1'b1);
      check_val("ram_holds_a5", rd_mem(16'h1234), 8'hA5);
      txn(1'b0, 1'b0, 16'h1234, 8'h00, 1'b0, 1'b1);
      check_val("d_dat_hold", d_dat_o, pat(16'h0403));

      // Write protect region.
      wp_lock = 1;
      txn(1'b0, 1'b1, 16'h0100, 8'h77, 1'b0, 1'b1);
`ifdef CHAR_RAM_ARB_WRPROT_EN
      check_val("wp_cpu_low", rd_mem(16'h0100), pat(16'h0100));
`else
      check_val("wp_cpu_low", rd_mem(16'h0100), 8'h77);
`endif
      txn(1'b0, 1'b1, 16'h2000, 8'h88, 1'b0, 1'b1);
      check_val("wp_cpu_top", rd_mem(16'h2000), 8'h88);
      txn(1'b1, 1'b1, 16'h0100, 8'h99, 1'b0, 1'b1);
      check_val("wp_dma_low", rd_mem(16'h0100), 8'h99);
      wp_lock = 0;

      // Reset during the second select cycle of a read.
      c_we = 0; c_adr = 16'h0500; c_req = 1;
      @(posedge clk);
      @(posedge clk); #1;
      check_val("pre_rst_cs", ram_cs_o, 1);
      rst_n = 0;
      #1;
      check_val("rst_cs_drop", {ram_cs_o, ram_we_o}, 0);
      check_val("rst_busy", busy_o, 0);
      check_val("rst_no_ack", c_ack_o, 0);
      repeat (2) @(posedge clk); #1;
      rst_n = 1;
      it.we = 0; it.adr = 16'h0500; it.dat = rd_mem(16'h0500);
      it.issue = cyc; it.chk_lat = 1;
      cq.push_back(it);
      wait_ack(1'b0, "post_rst");
      @(posedge clk); #1;
      c_req = 0;

      // Fixed priority: CPU never drops, DMA must starve until it does.
      fc_acks = 0; fd_acks = 0;
      fc_req = 1; fd_req = 1;
      repeat (30) @(posedge clk); #1;
      check_val("fp_dma_starved", fd_acks, 0);
      check_val("fp_cpu_served", fc_acks >= 5, 1);
      fc_req = 0;
      for (k = 0; k < 40; k++) begin
         @(negedge clk);
         if (fd_ack_o) break;
      end
      if (k == 40) check_val("fp_dma_timeout", 0, 1);
      check_val("fp_dma_dat", fd_dat_o, 8'h5A);
      @(posedge clk); #1;
      fd_req = 0;

      repeat (6) @(posedge clk); #1;
      check_val("cq_empty", cq.size(), 0);
      check_val("dq_empty", dq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
